// File: rtl/cam_capture_core.sv
// cam_capture_core: parallel camera capture front end.
// Assembles BPP bus beats into one pixel and tracks the pixel column and line.
// Frame sequencing: IDLE -> VBLANK -> ACTIVE (captured) or SKIP (dropped).
//
// Ports
//   pclk, rst_n    : pixel clock; asynchronous active-low reset
//   vsync, href, d : camera frame sync (polarity VSYNC_POL), line valid, data
//   enable, skip   : allow new frames; number of frames dropped after each capture
//   pixel_data/x/y : assembled pixel and its column and line, qualified by pixel_valid
//   sof, eol       : start-of-frame strobe (with first pixel) and end-of-line strobe
//   frame_done     : end of a captured frame
//   line_err       : line ended mid-pixel, overflowed, or had a different length than line 0
//   frame_count    : number of captured frames, wraps at 16 bits
module cam_capture_core #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned BPP       = 2,
  parameter int unsigned X_BITS    = 11,
  parameter int unsigned Y_BITS    = 10,
  parameter int unsigned VSYNC_POL = 1,
  parameter int unsigned SWAP      = 0
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                href,
  input  logic [IN_W-1:0]     d,
  input  logic                enable,
  input  logic [3:0]          skip,
  output logic [IN_W*BPP-1:0] pixel_data,
  output logic                pixel_valid,
  output logic [X_BITS-1:0]   pixel_x,
  output logic [Y_BITS-1:0]   pixel_y,
  output logic                sof,
  output logic                eol,
  output logic                frame_done,
  output logic                line_err,
  output logic [15:0]         frame_count
);

  localparam int unsigned PW = IN_W * BPP;
  localparam int unsigned BW = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic [1:0] {StIdle, StVblank, StActive, StSkip} state_e;

  state_e state_q, state_d;

  logic              vs_act, vs_q, href_q;
  logic              vs_rise, vs_fall;
  logic [BW-1:0]     beat_q;
  logic [PW-1:0]     sh_q, sh_nxt;
  logic [X_BITS:0]   lp_q, ref_q;   // pixels on this line / on line 0, saturating
  logic              have_ref_q, ovf_q, first_q;
  logic [Y_BITS-1:0] y_cnt_q;
  logic [3:0]        skip_cnt_q;
  logic              last_beat, capturing, beat_en, pix_done, line_end;
  logic              frame_start, frame_end, skip_end;

  assign vs_act  = (vsync == 1'(VSYNC_POL));
  assign vs_rise = vs_act & ~vs_q;
  assign vs_fall = ~vs_act & vs_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:           if (vs_rise) state_d = StVblank;
      StVblank:         if (vs_fall) state_d = (enable && skip_cnt_q == '0) ? StActive : StSkip;
      StActive, StSkip: if (vs_rise) state_d = StVblank;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign frame_start = (state_q == StVblank) && (state_d == StActive);
  assign frame_end   = (state_q == StActive) && vs_rise;
  assign skip_end    = (state_q == StSkip) && vs_rise;
  // A vs_act rise wins over href, so a line cut short by vsync produces no pixel or eol.
  assign capturing   = (state_q == StActive) && !vs_act;
  assign beat_en     = capturing && href;
  assign last_beat   = (beat_q == BW'(BPP - 1));
  assign pix_done    = beat_en && last_beat;
  assign line_end    = capturing && href_q && !href;

  always_comb begin
    if (SWAP == 0) sh_nxt = (sh_q << IN_W) | PW'(d);
    else           sh_nxt = (sh_q >> IN_W) | (PW'(d) << (PW - IN_W));
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      // vs_q starts "active" so a vsync already asserted at release is not taken as a rise.
      vs_q        <= 1'b1;
      href_q      <= 1'b0;
      beat_q      <= '0;
      sh_q        <= '0;
      lp_q        <= '0;
      ref_q       <= '0;
      have_ref_q  <= 1'b0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b0;
      y_cnt_q     <= '0;
      skip_cnt_q  <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_q        <= vs_act;
      href_q      <= href;
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;

      if (beat_en) begin
        sh_q   <= sh_nxt;
        beat_q <= last_beat ? '0 : beat_q + BW'(1);
      end else begin
        beat_q <= '0;
      end

      if (pix_done) begin
        pixel_data  <= sh_nxt;
        pixel_valid <= 1'b1;
        pixel_x     <= lp_q[X_BITS] ? {X_BITS{1'b1}} : lp_q[X_BITS-1:0];
        pixel_y     <= y_cnt_q;
        sof         <= first_q;
        first_q     <= 1'b0;
        if (lp_q[X_BITS]) ovf_q <= 1'b1;
        else              lp_q  <= lp_q + (X_BITS + 1)'(1);
      end

      if (line_end) begin
        if (lp_q != '0) begin
          eol      <= 1'b1;
          line_err <= (beat_q != '0) || ovf_q || (have_ref_q && lp_q != ref_q);
          if (!have_ref_q) begin
            ref_q      <= lp_q;
            have_ref_q <= 1'b1;
          end
          if (y_cnt_q != '1) y_cnt_q <= y_cnt_q + Y_BITS'(1);
        end
        lp_q  <= '0;
        ovf_q <= 1'b0;
      end

      if (frame_start) begin
        y_cnt_q    <= '0;
        have_ref_q <= 1'b0;
        lp_q       <= '0;
        ovf_q      <= 1'b0;
        first_q    <= 1'b1;
      end

      if (frame_end) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
        skip_cnt_q  <= skip;
        lp_q        <= '0;
        ovf_q       <= 1'b0;
        first_q     <= 1'b0;
      end

      if (skip_end && skip_cnt_q != '0) skip_cnt_q <= skip_cnt_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_cam_capture_core.sv
// Directed bench for cam_capture_core (BPP=2, 8-bit bus).
// Two instances share stimulus: SWAP=0 and SWAP=1.
module tb_cam_capture_core;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  d = '0;
  logic        enable = 1'b1;
  logic [3:0]  skip = '0;

  logic [15:0] a_pd, b_pd;
  logic        a_pv, b_pv, a_sof, b_sof, a_eol, b_eol, a_fd, b_fd, a_le, b_le;
  logic [10:0] a_x, b_x;
  logic [9:0]  a_y, b_y;
  logic [15:0] a_fc, b_fc;

  always #5 pclk = ~pclk;

  cam_capture_core #(.SWAP(0)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
    .skip(skip), .pixel_data(a_pd), .pixel_valid(a_pv), .pixel_x(a_x), .pixel_y(a_y),
    .sof(a_sof), .eol(a_eol), .frame_done(a_fd), .line_err(a_le), .frame_count(a_fc)
  );

  cam_capture_core #(.SWAP(1)) u_swp (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
    .skip(skip), .pixel_data(b_pd), .pixel_valid(b_pv), .pixel_x(b_x), .pixel_y(b_y),
    .sof(b_sof), .eol(b_eol), .frame_done(b_fd), .line_err(b_le), .frame_count(b_fc)
  );

  // One row = inputs for one clock plus the outputs expected right after that edge.
  typedef struct {
    logic        vs, hr;
    logic [7:0]  d;
    logic        pv;
    logic [15:0] pd, pds;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof, eol, le, fd;
    logic [15:0] fc;
  } vec_t;

  vec_t       tbl[$];
  int         fc_m = 0;
  logic [7:0] bval = 8'h12;
  int         nvec = 0;
  int         nfail = 0;

  function automatic vec_t mk(input logic vs, input logic hr, input logic [7:0] dd);
    vec_t v;
    v = '{default: '0};
    v.vs = vs;
    v.hr = hr;
    v.d  = dd;
    v.fc = 16'(fc_m);
    return v;
  endfunction

  task automatic add_idle(input int n);
    repeat (n) tbl.push_back(mk(1'b0, 1'b0, 8'h00));
  endtask

  task automatic add_vsync(input bit ends_frame);
    vec_t v;
    if (ends_frame) fc_m++;
    v = mk(1'b1, 1'b0, 8'h00);
    v.fd = ends_frame;
    tbl.push_back(v);
    tbl.push_back(mk(1'b1, 1'b0, 8'h00));
    add_idle(2);
  endtask

  task automatic add_bytes(input int nbytes, input int y, input bit first);
    vec_t v;
    logic [7:0] prev;
    prev = '0;
    for (int i = 0; i < nbytes; i++) begin
      v = mk(1'b0, 1'b1, bval);
      if (i % 2 == 1) begin
        v.pv  = 1'b1;
        v.pd  = {prev, bval};
        v.pds = {bval, prev};
        v.x   = 11'(i / 2);
        v.y   = 10'(y);
        v.sof = first && (i == 1);
      end
      tbl.push_back(v);
      prev = bval;
      bval = bval + 8'h22;
    end
  endtask

  task automatic add_line(input int nbytes, input int y, input bit first, input bit err);
    vec_t v;
    add_bytes(nbytes, y, first);
    v = mk(1'b0, 1'b0, 8'h00);
    v.eol = (nbytes >= 2);
    v.le  = err;
    tbl.push_back(v);
    add_idle(1);
  endtask

  // Line cut by vsync while href is still high: frame_done, no eol.
  task automatic add_cut_line(input int nbytes, input int y);
    vec_t v;
    add_bytes(nbytes, y, 1'b0);
    fc_m++;
    v = mk(1'b1, 1'b1, bval);
    v.fd = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk(1'b1, 1'b0, 8'h00));
    add_idle(2);
  endtask

  task automatic step(input logic vs, input logic hr, input logic [7:0] dd);
    @(negedge pclk);
    vsync = vs;
    href  = hr;
    d     = dd;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int i);
    vec_t e;
    bit ok;
    e = tbl[i];
    nvec++;
    ok = (a_pv === e.pv) && (a_sof === e.sof) && (a_eol === e.eol) && (a_le === e.le) &&
         (a_fd === e.fd) && (a_fc === e.fc);
    if (e.pv)
      ok = ok && (a_pd === e.pd) && (b_pd === e.pds) && (a_x === e.x) && (a_y === e.y);
    if (!ok) begin
      nfail++;
      $display("FAIL vec%0d: got pv=%b pd=%h/%h x=%0d y=%0d sof=%b eol=%b le=%b fd=%b fc=%0d; expected pv=%b pd=%h/%h x=%0d y=%0d sof=%b eol=%b le=%b fd=%b fc=%0d",
               i, a_pv, a_pd, b_pd, a_x, a_y, a_sof, a_eol, a_le, a_fd, a_fc,
               e.pv, e.pd, e.pds, e.x, e.y, e.sof, e.eol, e.le, e.fd, e.fc);
    end
  endtask

  // One vsync pulse followed by an 8-byte line; counts pixel strobes seen.
  task automatic frame_line(output int pv_n, output int eol_n);
    pv_n  = 0;
    eol_n = 0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i < 8, 8'(8'h40 + i));
      pv_n  += int'(a_pv);
      eol_n += int'(a_eol);
    end
  endtask

  initial begin
    int pvc, eolc, fdc;
    int exp_pv[6];

    // Frame 1: 4x3 clean frame. Frame 2: odd line 1. Frame 3: vsync cuts line 2.
    add_idle(3);
    add_vsync(1'b0);
    add_line(8, 0, 1'b1, 1'b0);
    add_line(8, 1, 1'b0, 1'b0);
    add_line(8, 2, 1'b0, 1'b0);
    add_vsync(1'b1);
    add_line(8, 0, 1'b1, 1'b0);
    add_line(7, 1, 1'b0, 1'b1);
    add_line(8, 2, 1'b0, 1'b0);
    add_vsync(1'b1);
    add_line(8, 0, 1'b1, 1'b0);
    add_line(8, 1, 1'b0, 1'b0);
    add_cut_line(4, 2);

    // Reset state
    #12;
    chk("rst_pv", 32'(a_pv), 32'd0);
    chk("rst_pd", 32'(a_pd), 32'd0);
    chk("rst_fc", 32'(a_fc), 32'd0);
    chk("rst_strobes", {a_sof, a_eol, a_fd, a_le}, 32'd0);
    chk("rst_xy", {a_x, a_y}, 32'd0);
    @(negedge pclk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].vs, tbl[i].hr, tbl[i].d);
      check_vec(i);
    end

    // Reset asserted mid-line while a pixel strobe is showing.
    step(1'b0, 1'b1, 8'hA1);
    step(1'b0, 1'b1, 8'hB2);
    chk("pre_rst_pv", 32'(a_pv), 32'd1);
    @(negedge pclk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pv", 32'(a_pv), 32'd0);
    chk("async_rst_pd", 32'(a_pd), 32'd0);
    chk("async_rst_fc", 32'(a_fc), 32'd0);
    step(1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b1, 8'hD4);
    @(negedge pclk);
    rst_n = 1'b1;
    pvc  = 0;
    eolc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i < 8, 8'(i));
      pvc  += int'(a_pv);
      eolc += int'(a_eol);
    end
    chk("post_rst_no_pix", 32'(pvc), 32'd0);
    chk("post_rst_no_eol", 32'(eolc), 32'd0);
    frame_line(pvc, eolc);
    chk("after_vsync_pix", 32'(pvc), 32'd4);
    chk("after_vsync_eol", 32'(eolc), 32'd1);

    // Frame skipping: skip=2 over 6 frames captures frames 1 and 4.
    @(negedge pclk);
    rst_n = 1'b0;
    skip  = 4'd2;
    step(1'b0, 1'b0, 8'h00);
    @(negedge pclk);
    rst_n = 1'b1;
    exp_pv = '{4, 0, 0, 4, 0, 0};
    fdc = 0;
    for (int f = 0; f < 6; f++) begin
      frame_line(pvc, eolc);
      fdc += (f == 1 || f == 4) ? 1 : 0;
      chk($sformatf("skip_frame%0d_pix", f + 1), 32'(pvc), 32'(exp_pv[f]));
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("skip_frame_count", 32'(a_fc), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
